fp_addsub_param: RTL and testbench

- Parametrised successor to the team's fixed 32-bit custom floating-point adder. Format: 1 sign bit, EXP_W-bit biased exponent, MAN_W-bit fraction with a hidden leading 1.
- Adds or subtracts two operands through a multi-cycle FSM, using valid/ready handshakes on both input and output.
- Provides round-to-nearest-even using guard/round/sticky bits, plus a status code. Sits between the operand source and result consumer in the arithmetic datapath.

---
 rtl/fp_param_pkg.sv | 36 +++
 rtl/fp_align_shifter.sv | 27 ++
 rtl/fp_addsub_param.sv | 167 ++++++++++++++++
 tb/tb_fp_addsub_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_param_pkg.sv
// Shared types for the parametrised floating-point add/sub unit:
// FSM states, status codes and a width-generic field extractor.
package fp_param_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] ST_EXACT   = 4'd0;
  localparam logic [3:0] ST_OVF     = 4'd1;
  localparam logic [3:0] ST_UNF     = 4'd2;
  localparam logic [3:0] ST_INEXACT = 4'd3;

  localparam int FLD_W = 64;

  typedef enum logic [1:0] {F_SIGN, F_EXP, F_FRAC} field_t;

  // Returns one field of a 1+exp_w+man_w word, right-justified; callers truncate.
  function automatic logic [FLD_W-1:0] fp_field(input logic [FLD_W-1:0] word,
                                                input int exp_w, input int man_w,
                                                input field_t sel);
    logic [FLD_W-1:0] one;
    one = FLD_W'(1);
    case (sel)
      F_SIGN:  return FLD_W'(word[exp_w+man_w]);
      F_EXP:   return (word >> man_w) & ((one << exp_w) - one);
      default: return word & ((one << man_w) - one);
    endcase
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right barrel shift for mantissa alignment; every bit shifted out
// is folded into the sticky position (bit 0).
module fp_align_shifter #(
  parameter int WID  = 29,
  parameter int SH_W = 6
) (
  input  logic [WID-1:0]  din,
  input  logic [SH_W-1:0] shamt,
  output logic [WID-1:0]  dout
);

  logic lost;

  always_comb begin
    dout = '0;
    lost = 1'b0;
    if (int'(shamt) >= WID) begin
      lost = |din;
    end else begin
      dout = din >> shamt;
      for (int i = 0; i < WID; i++)
        if (i < int'(shamt)) lost = lost | din[i];
    end
    dout[0] = dout[0] | lost;
  end

endmodule

// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with round-to-nearest-even,
// valid/ready on both sides and a saturating/flushing status code.
module fp_addsub_param
  import fp_param_pkg::*;
#(
  parameter  int EXP_W = 6,
  parameter  int MAN_W = 25,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100kHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic [2:0]   state_out
);

  localparam int MW = MAN_W + 4;  // hidden, fraction, G, R, S
  localparam int XW = EXP_W + 2;  // headroom for carry/round exponent growth
  localparam int CW = $clog2(MW) + 1;
  localparam logic [XW-1:0]    EMAX     = XW'((1 << EXP_W) - 2);
  localparam logic [CW-1:0]    NORM_MAX = CW'(MAN_W + 3);
  localparam logic [EXP_W-1:0] EXP_SAT  = EXP_W'((1 << EXP_W) - 2);

  state_t state, state_nx;

  logic             s_a, eff_sub, unf;
  logic [XW-1:0]    e_a;
  logic [EXP_W-1:0] d;
  logic [MW:0]      m_a;   // extra top bit is the add carry
  logic [MW-1:0]    m_b, m_b_sh;
  logic [CW-1:0]    norm_cnt;

  // operand capture
  logic             sa_in, sb_in, swap;
  logic [EXP_W-1:0] ea_in, eb_in;
  logic [MAN_W-1:0] fa_in, fb_in;

  always_comb begin
    sa_in = fp_field(FLD_W'(op_A_in), EXP_W, MAN_W, F_SIGN) != '0;
    sb_in = (fp_field(FLD_W'(op_B_in), EXP_W, MAN_W, F_SIGN) != '0) ^ op_sub;
    ea_in = EXP_W'(fp_field(FLD_W'(op_A_in), EXP_W, MAN_W, F_EXP));
    eb_in = EXP_W'(fp_field(FLD_W'(op_B_in), EXP_W, MAN_W, F_EXP));
    fa_in = (ea_in == '0) ? '0 : MAN_W'(fp_field(FLD_W'(op_A_in), EXP_W, MAN_W, F_FRAC));
    fb_in = (eb_in == '0) ? '0 : MAN_W'(fp_field(FLD_W'(op_B_in), EXP_W, MAN_W, F_FRAC));
    swap  = {eb_in, fb_in} > {ea_in, fa_in};
  end

  fp_align_shifter #(.WID(MW), .SH_W(EXP_W)) u_align (
    .din   (m_b),
    .shamt (d),
    .dout  (m_b_sh)
  );

  logic [MW:0] add_res;
  logic        norm_left, norm_unf, norm_stop;
  logic        rnd_inc, inexact, ovf;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]    e_fin;
  logic [MAN_W-1:0] f_fin;

  always_comb begin
    add_res   = eff_sub ? m_a - {1'b0, m_b} : m_a + {1'b0, m_b};
    norm_left = !m_a[MW] && !m_a[MW-1];
    norm_unf  = norm_left && (e_a <= XW'(1));
    norm_stop = norm_left && (norm_cnt == NORM_MAX);
    // nearest-even: round up above half, or at exactly half with odd lsb
    rnd_inc   = m_a[2] & (m_a[1] | m_a[0] | m_a[3]);
    inexact   = |m_a[2:0];
    rnd       = {1'b0, m_a[MW-1:3]} + (MAN_W+2)'(rnd_inc);
    e_fin     = e_a + XW'(rnd[MAN_W+1]);
    f_fin     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    ovf       = e_fin > EMAX;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = ALIGN;
      ALIGN: state_nx = ADD;
      ADD:   state_nx = (add_res == '0) ? DONE : NORM;
      // a carry shift always leaves the hidden bit set, so it goes straight on
      NORM:  if (m_a[MW] || !norm_left || norm_unf || norm_stop) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      s_a        <= 1'b0;
      eff_sub    <= 1'b0;
      unf        <= 1'b0;
      e_a        <= '0;
      d          <= '0;
      m_a        <= '0;
      m_b        <= '0;
      norm_cnt   <= '0;
      data_out   <= '0;
      status_out <= ST_EXACT;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          s_a      <= swap ? sb_in : sa_in;
          eff_sub  <= sa_in ^ sb_in;
          e_a      <= XW'(swap ? eb_in : ea_in);
          d        <= swap ? eb_in - ea_in : ea_in - eb_in;
          m_a      <= swap ? {1'b0, |eb_in, fb_in, 3'b000} : {1'b0, |ea_in, fa_in, 3'b000};
          m_b      <= swap ? {|ea_in, fa_in, 3'b000} : {|eb_in, fb_in, 3'b000};
          unf      <= 1'b0;
          norm_cnt <= '0;
        end
        ALIGN: m_b <= m_b_sh;
        ADD: begin
          m_a <= add_res;
          if (add_res == '0) begin
            data_out   <= '0;
            status_out <= ST_EXACT;
          end
        end
        NORM: begin
          if (m_a[MW]) begin
            m_a <= {1'b0, m_a[MW:2], m_a[1] | m_a[0]};
            e_a <= e_a + XW'(1);
          end else if (norm_left) begin
            if (norm_unf) unf <= 1'b1;
            else if (!norm_stop) begin
              m_a      <= m_a << 1;
              e_a      <= e_a - XW'(1);
              norm_cnt <= norm_cnt + CW'(1);
            end
          end
        end
        ROUND: begin
          if (ovf) begin
            data_out   <= {s_a, EXP_SAT, {MAN_W{1'b1}}};
            status_out <= ST_OVF;
          end else if (unf) begin
            data_out   <= {s_a, {(W-1){1'b0}}};
            status_out <= ST_UNF;
          end else begin
            data_out   <= {s_a, e_fin[EXP_W-1:0], f_fin};
            status_out <= inexact ? ST_INEXACT : ST_EXACT;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_out = state;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: directed table, randomized ops against an
// exact-arithmetic reference, and handshake / mid-operation reset sequences.
module tb_fp_addsub_param;

  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clock_100kHz = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] op_A_in, op_B_in, data_out;
  logic [3:0]   status_out;
  logic [2:0]   state_out;

  int errors = 0;
  int checks = 0;

  fp_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_sub       (op_sub),
    .op_A_in      (op_A_in),
    .op_B_in      (op_B_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .status_out   (status_out),
    .state_out    (state_out)
  );

  always #5 clock_100kHz = ~clock_100kHz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact reference: scale both operands to a common integer grid, add,
  // then round the exact magnitude to 26 significant bits.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                    output logic [31:0] res, output logic [3:0] st);
    int ea, eb, emin, p, e, k;
    logic [127:0] ma, mb, mag, keep, rem, half;
    logic sa, sb, s;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    ma = (ea == 0) ? '0 : 128'({1'b1, a[24:0]});
    mb = (eb == 0) ? '0 : 128'({1'b1, b[24:0]});
    emin = (ea < eb) ? ea : eb;
    ma = ma << (ea - emin);
    mb = mb << (eb - emin);
    if (sa == sb)      begin mag = ma + mb; s = sa; end
    else if (ma >= mb) begin mag = ma - mb; s = sa; end
    else               begin mag = mb - ma; s = sb; end
    res = '0;
    st  = 4'd0;
    if (mag == '0) return;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = emin + p - MAN_W;
    if (e < 1) begin
      res = {s, 31'b0};
      st  = 4'd2;
      return;
    end
    if (p > MAN_W) begin
      k    = p - MAN_W;
      keep = mag >> k;
      rem  = mag & ((128'd1 << k) - 128'd1);
      half = 128'd1 << (k - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
      st = (rem != '0) ? 4'd3 : 4'd0;
    end else begin
      keep = mag << (MAN_W - p);
    end
    if (keep[26]) begin
      keep = keep >> 1;
      e++;
    end
    if (e > 62) begin
      res = {s, 6'd62, {25{1'b1}}};
      st  = 4'd1;
      return;
    end
    res = {s, 6'(e), keep[24:0]};
  endfunction

  // Issue one operation and wait (bounded) for its result; lat counts
  // clock edges starting with the accepting edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] d, output logic [3:0] st, output int lat);
    @(negedge clock_100kHz);
    chk("in_ready_before_op", 64'(in_ready), 64'd1);
    op_A_in = a; op_B_in = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clock_100kHz);
    lat = 1;
    @(negedge clock_100kHz);
    in_valid = 1'b0;
    op_A_in = $urandom; op_B_in = $urandom; op_sub = 1'($urandom);
    while (!out_valid && lat < 60) begin
      @(posedge clock_100kHz);
      lat++;
      @(negedge clock_100kHz);
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    d  = data_out;
    st = status_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clock_100kHz);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] exp_d;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd, ed, ra, rb;
    logic [3:0]  rs, es;
    logic        rsub, seen;
    int          lat, ea, eb, mode, waitc;

    vecs[0]  = '{"one_plus_one",   32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'd0};
    vecs[1]  = '{"one_minus_one",  32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'd0};
    vecs[2]  = '{"tiny_addend",    32'h3E000000, 32'h08000000, 1'b0, 32'h3E000000, 4'd3};
    vecs[3]  = '{"max_overflow",   32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7DFFFFFF, 4'd1};
    vecs[4]  = '{"underflow",      32'h03000000, 32'h02000000, 1'b1, 32'h00000000, 4'd2};
    vecs[5]  = '{"cancel_to_ulp",  32'h3E000001, 32'h3E000000, 1'b1, 32'h0C000000, 4'd0};
    vecs[6]  = '{"tie_even_down",  32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'd3};
    vecs[7]  = '{"tie_odd_up",     32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'd3};
    vecs[8]  = '{"neg_sum",        32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'd0};
    vecs[9]  = '{"swap_neg_diff",  32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'd0};
    vecs[10] = '{"zero_plus_one",  32'h00000000, 32'h3E000000, 1'b0, 32'h3E000000, 4'd0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
    op_A_in = '0; op_B_in = '0;
    repeat (2) @(negedge clock_100kHz);
    chk("rst_in_ready",  64'(in_ready),   64'd1);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_data",      64'(data_out),   64'd0);
    chk("rst_status",    64'(status_out), 64'd0);
    chk("rst_state",     64'(state_out),  64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rd, rs, lat);
      chk({vecs[i].name, "_data"},   64'(rd), 64'(vecs[i].exp_d));
      chk({vecs[i].name, "_status"}, 64'(rs), 64'(vecs[i].exp_st));
      if (i == 0) chk("latency_one_plus_one", 64'(lat), 64'd5);
      release_out();
    end

    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 7));
      ea   = (mode == 6) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 62));
      ra   = {1'($urandom), 6'(ea), 25'($urandom)};
      if (mode < 4) begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        if (eb < 1)  eb = 1;
        if (eb > 62) eb = 62;
      end else if (mode == 4) eb = 0;
      else if (mode == 6)     eb = int'($urandom_range(1, 3));
      else                    eb = int'($urandom_range(1, 62));
      rb = {1'($urandom), 6'(eb), 25'($urandom)};
      if (mode == 5) rb = {1'($urandom), ra[30:2], 2'($urandom)};
      rsub = 1'($urandom);
      ref_model(ra, rb, rsub, ed, es);
      run_op(ra, rb, rsub, rd, rs, lat);
      if ({rs, rd} !== {es, ed})
        $display("  operands a=%h b=%h sub=%0d", ra, rb, rsub);
      chk("random_result", 64'({rs, rd}), 64'({es, ed}));
      release_out();
    end

    // consumer stalls; inputs offered meanwhile must be ignored
    run_op(32'h3E000000, 32'h3E000000, 1'b0, rd, rs, lat);
    for (int c = 0; c < 10; c++) begin
      op_A_in = $urandom; op_B_in = $urandom; in_valid = 1'b1;
      @(negedge clock_100kHz);
      chk("stall_data",      64'(data_out),  64'h40000000);
      chk("stall_in_ready",  64'(in_ready),  64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    release_out();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid || state_out != 3'd0) seen = 1'b1;
      @(negedge clock_100kHz);
    end
    chk("stall_nothing_accepted", 64'(seen), 64'd0);

    // reset while normalising a long cancellation
    @(negedge clock_100kHz);
    op_A_in = 32'h3E000001; op_B_in = 32'h3E000000; op_sub = 1'b1; in_valid = 1'b1;
    @(negedge clock_100kHz);
    in_valid = 1'b0;
    waitc = 0;
    while (state_out != 3'd3 && waitc < 10) begin
      @(negedge clock_100kHz);
      waitc++;
    end
    repeat (2) @(negedge clock_100kHz);
    chk("mid_norm_state", 64'(state_out), 64'd3);
    reset = 1'b1;
    #1;
    chk("rst_norm_state",     64'(state_out), 64'd0);
    chk("rst_norm_out_valid", 64'(out_valid), 64'd0);
    @(negedge clock_100kHz);
    reset = 1'b0;
    @(negedge clock_100kHz);
    chk("rst_norm_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clock_100kHz);
    end
    chk("rst_norm_no_result", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
